strided_dilated_window: RTL and testbench

// Next-generation window generator for the convolution pipeline. It replaces the separate

---
 rtl/strided_dilated_window.sv | 159 +++++++++++++++
 tb/tb_strided_dilated_window.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/strided_dilated_window.sv
// Padded, strided and dilated KHxKW window generator: one padded-frame position per cycle,
// SpanY-1 line buffers plus a SpanX-deep column shift, single-entry output register.
module strided_dilated_window #(
    parameter int InHeight      = 600,
    parameter int InWidth       = 800,
    parameter int KernelHeight  = 3,
    parameter int KernelWidth   = 3,
    parameter int StrideY       = 1,
    parameter int StrideX       = 1,
    parameter int DilationY     = 1,
    parameter int DilationX     = 1,
    parameter int PaddingTop    = 1,
    parameter int PaddingBottom = 1,
    parameter int PaddingLeft   = 1,
    parameter int PaddingRight  = 1,
    parameter int DataWidth     = 24,
    parameter logic [DataWidth-1:0] PaddingValue = '0
) (
    input  logic                                              clock_i,
    input  logic                                              reset_i,
    input  logic                                              slave_valid_i,
    output logic                                              slave_ready_o,
    input  logic [DataWidth-1:0]                              slave_data_i,
    output logic                                              master_valid_o,
    input  logic                                              master_ready_i,
    output logic [KernelHeight*KernelWidth*DataWidth-1:0]     master_data_o
);
    localparam int PH    = InHeight + PaddingTop + PaddingBottom;
    localparam int PW    = InWidth + PaddingLeft + PaddingRight;
    localparam int SpanY = (KernelHeight - 1) * DilationY + 1;
    localparam int SpanX = (KernelWidth - 1) * DilationX + 1;
    localparam int NT    = KernelHeight * KernelWidth;
    localparam int PR_W  = (PH > 1) ? $clog2(PH) : 1;
    localparam int PC_W  = (PW > 1) ? $clog2(PW) : 1;
    localparam int SY_W  = (StrideY > 1) ? $clog2(StrideY) : 1;
    localparam int SX_W  = (StrideX > 1) ? $clog2(StrideX) : 1;

    localparam logic [PR_W-1:0] PR_LAST = PR_W'(PH - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PW - 1);
    localparam logic [SY_W-1:0] SY_LAST = SY_W'(StrideY - 1);
    localparam logic [SX_W-1:0] SX_LAST = SX_W'(StrideX - 1);

    if (SpanY > PH || SpanX > PW) begin : g_bad_geometry
        $error("strided_dilated_window: dilated kernel span exceeds padded frame");
    end

    logic [PR_W-1:0]           pr_q;
    logic [PC_W-1:0]           pc_q;
    logic [SY_W-1:0]           phy_q;
    logic [SX_W-1:0]           phx_q;
    logic                      out_valid_q;
    logic [NT*DataWidth-1:0]   out_data_q;
    logic [NT*DataWidth-1:0]   out_data_d;

    logic                      is_input, is_emit, out_free, adv, load, row_end, frame_end;
    logic [DataWidth-1:0]      elem;
    logic [DataWidth-1:0]      col    [SpanY];
    logic [DataWidth-1:0]      full_d [SpanY][SpanX];

    assign is_input = int'(pr_q) >= PaddingTop  && int'(pr_q) < PaddingTop + InHeight &&
                      int'(pc_q) >= PaddingLeft && int'(pc_q) < PaddingLeft + InWidth;

    // Integer division floors, so a phase-0 origin always fits in the frame: the OH/OW
    // upper bound on origins is implied by the phase counters alone.
    assign is_emit  = int'(pr_q) >= SpanY - 1 && phy_q == '0 &&
                      int'(pc_q) >= SpanX - 1 && phx_q == '0;

    assign out_free      = !out_valid_q || master_ready_i;
    assign adv           = (!is_input || slave_valid_i) && (!is_emit || out_free);
    assign load          = adv && is_emit;
    assign slave_ready_o = !reset_i && is_input && (!is_emit || out_free);
    assign elem          = is_input ? slave_data_i : PaddingValue;
    assign row_end       = pc_q == PC_LAST;
    assign frame_end     = row_end && pr_q == PR_LAST;

    // Column vector at pc: oldest row first, the incoming element last.
    if (SpanY > 1) begin : g_rows
        logic [DataWidth-1:0] rowbuf_q [SpanY-1][PW];

        always_comb begin
            for (int k = 0; k < SpanY - 1; k++) col[k] = rowbuf_q[k][pc_q];
            col[SpanY-1] = elem;
        end

        always_ff @(posedge clock_i) begin
            if (adv) begin
                for (int k = 0; k < SpanY - 1; k++) rowbuf_q[k][pc_q] <= col[k+1];
            end
        end
    end else begin : g_no_rows
        always_comb col[0] = elem;
    end

    if (SpanX > 1) begin : g_cols
        logic [DataWidth-1:0] win_q [SpanY][SpanX-1];

        always_comb begin
            for (int k = 0; k < SpanY; k++) begin
                for (int x = 0; x < SpanX - 1; x++) full_d[k][x] = win_q[k][x];
                full_d[k][SpanX-1] = col[k];
            end
        end

        always_ff @(posedge clock_i) begin
            if (adv) begin
                for (int k = 0; k < SpanY; k++)
                    for (int x = 0; x < SpanX - 1; x++) win_q[k][x] <= full_d[k][x+1];
            end
        end
    end else begin : g_no_cols
        always_comb begin
            for (int k = 0; k < SpanY; k++) full_d[k][0] = col[k];
        end
    end

    always_comb begin
        out_data_d = '0;
        for (int i = 0; i < KernelHeight; i++)
            for (int j = 0; j < KernelWidth; j++)
                out_data_d[(i*KernelWidth+j)*DataWidth +: DataWidth] = full_d[i*DilationY][j*DilationX];
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pr_q        <= '0;
            pc_q        <= '0;
            phy_q       <= '0;
            phx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (adv) begin
                if (row_end) begin
                    pc_q  <= '0;
                    phx_q <= '0;
                    if (frame_end) begin
                        pr_q  <= '0;
                        phy_q <= '0;
                    end else begin
                        pr_q <= pr_q + 1'b1;
                        if (int'(pr_q) >= SpanY - 1) phy_q <= (phy_q == SY_LAST) ? '0 : phy_q + 1'b1;
                    end
                end else begin
                    pc_q <= pc_q + 1'b1;
                    if (int'(pc_q) >= SpanX - 1) phx_q <= (phx_q == SX_LAST) ? '0 : phx_q + 1'b1;
                end
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
            end else if (master_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign master_valid_o = out_valid_q;
    assign master_data_o  = out_data_q;
endmodule

// File: tb/tb_strided_dilated_window.sv
// Randomized scoreboard bench for strided_dilated_window on an asymmetric geometry
// (uneven padding, different strides and dilations per axis).
module tb_strided_dilated_window;
    localparam int IH = 5, IW = 7, KH = 2, KW = 3;
    localparam int SY = 2, SX = 2, DY = 2, DX = 1;
    localparam int PT = 1, PB = 2, PL = 2, PR = 0, DW = 8;
    localparam logic [DW-1:0] PADV = 8'hA5;
    localparam int PH = IH + PT + PB, PW = IW + PL + PR;
    localparam int OH = (PH - ((KH - 1) * DY + 1)) / SY + 1;
    localparam int OW = (PW - ((KW - 1) * DX + 1)) / SX + 1;
    localparam int NT = KH * KW;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0]      s_data;
    logic [NT*DW-1:0]   m_data;

    int checks = 0, failures = 0, cyc = 0, n_win = 0, n_acc = 0, exp_total = 0;
    int first_acc = 0, last_acc = 0, rdy_low = 0;
    logic [DW-1:0]      img [IH][IW];
    logic [NT*DW-1:0]   exp_q [$];

    strided_dilated_window #(
        .InHeight(IH), .InWidth(IW), .KernelHeight(KH), .KernelWidth(KW),
        .StrideY(SY), .StrideX(SX), .DilationY(DY), .DilationX(DX),
        .PaddingTop(PT), .PaddingBottom(PB), .PaddingLeft(PL), .PaddingRight(PR),
        .DataWidth(DW), .PaddingValue(PADV)
    ) dut (
        .clock_i(clk), .reset_i(rst),
        .slave_valid_i(s_valid), .slave_ready_o(s_ready), .slave_data_i(s_data),
        .master_valid_o(m_valid), .master_ready_i(m_ready), .master_data_o(m_data)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_ready = ($urandom_range(99) >= rdy_low);
        end
    end

    function automatic logic [DW-1:0] padded(input int r, input int c);
        if (r < PT || r >= PT + IH || c < PL || c >= PL + IW) return PADV;
        return img[r-PT][c-PL];
    endfunction

    task automatic push_windows();
        logic [NT*DW-1:0] w;
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
                w = '0;
                for (int i = 0; i < KH; i++)
                    for (int j = 0; j < KW; j++)
                        w[(i*KW+j)*DW +: DW] = padded(oy*SY + i*DY, ox*SX + j*DX);
                exp_q.push_back(w);
                exp_total++;
            end
    endtask

    // abort_at < 0: full frame with expectations; otherwise stop after abort_at elements.
    task automatic send_frame(input int pct_valid, input int abort_at);
        int idx, stall, lim;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) img[r][c] = 8'($urandom);
        lim = (abort_at < 0) ? IH * IW : abort_at;
        if (abort_at < 0) push_windows();
        idx = 0;
        stall = 0;
        while (idx < lim) begin
            s_valid = ($urandom_range(99) < pct_valid);
            s_data  = img[idx/IW][idx%IW];
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
                idx++;
                stall = 0;
            end else if (++stall > 500) begin
                checks++;
                failures++;
                $display("FAIL input_timeout idx=%0d", idx);
                idx = lim;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain remaining=%0d required=0", exp_q.size());
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s master_valid=%b slave_ready=%b required 0/0", name, m_valid, s_ready);
        end
    endtask

    // Monitor: pops on every output handshake and checks hold-stability under backpressure.
    initial begin
        logic             held;
        logic [NT*DW-1:0] held_data, w;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (rst || !m_valid) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (m_data !== held_data) begin
                        failures++;
                        $display("FAIL stall_stable got=%h required=%h", m_data, held_data);
                    end
                end
                if (m_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_window got=%h", m_data);
                    end else begin
                        w = exp_q.pop_front();
                        if (m_data !== w) begin
                            failures++;
                            $display("FAIL window%0d got=%h required=%h", n_win, m_data, w);
                        end
                    end
                    n_win++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = m_data;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        check_idle("reset_outputs");
        check_idle("reset_outputs_hold");
        @(posedge clk);
        #1 rst = 1'b0;

        // Two back-to-back full-rate frames: one position per cycle, no gap between frames.
        rdy_low = 0;
        send_frame(100, -1);
        send_frame(100, -1);
        checks++;
        if (last_acc - first_acc != PH*PW + (PT+IH-1)*PW + (PL+IW-1) - (PT*PW + PL)) begin
            failures++;
            $display("FAIL throughput span=%0d required=%0d", last_acc - first_acc,
                     PH*PW + (PT+IH-1)*PW + (PL+IW-1) - (PT*PW + PL));
        end
        wait_drain();

        // Random source gaps and sink backpressure.
        rdy_low = 30;
        for (int f = 0; f < 3; f++) send_frame(50, -1);
        wait_drain();

        // Partial frame with a window pending under backpressure, then reset.
        rdy_low = 100;
        send_frame(100, 9);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        check_idle("midreset_outputs");
        check_idle("midreset_outputs_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_low = 30;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL pending_discarded master_valid=%b required=0", m_valid);
        end
        @(posedge clk);
        #1;
        send_frame(60, -1);
        send_frame(100, -1);
        wait_drain();

        checks++;
        if (n_win != exp_total) begin
            failures++;
            $display("FAIL window_count got=%0d required=%0d", n_win, exp_total);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
